// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Single-issue instruction fetch stage with branch redirect,
//            stall hold and halt-on-zero-word.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
   parameter logic [15:0] RESET_PC     = 16'h0000,
   parameter bit          HALT_ON_ZERO = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   input  logic [15:0] imem_instruction,
   output logic [15:0] imem_address,
   output logic [15:0] instr_out,
   output logic [15:0] pc_out,
   output logic        instr_valid,
   output logic        halted
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nx;
   logic [15:0] r_fetch_pc;
   logic [15:0] w_fetch_pc_nx;
   logic [15:0] r_inflight_pc;
   logic [15:0] w_inflight_pc_nx;
   logic        r_inflight_valid;
   logic        w_inflight_valid_nx;
   logic [15:0] r_instr;
   logic [15:0] w_instr_nx;
   logic [15:0] r_pc;
   logic [15:0] w_pc_nx;
   logic        r_valid;
   logic        w_valid_nx;
   logic        w_redirect;
   logic        w_zero_word;

   assign w_redirect  = branch_taken && (r_state != ST_BOOT);
   assign w_zero_word = HALT_ON_ZERO && r_inflight_valid && (imem_instruction == 16'h0000);

   // Re-presenting the in-flight address during a stall keeps the memory
   // read data stable, so nothing is lost or duplicated on release.
   always_comb begin
      imem_address = r_fetch_pc;
      if (w_redirect) begin
         imem_address = branch_target;
      end else if (stall && (r_state == ST_RUN)) begin
         imem_address = r_inflight_pc;
      end
   end

   always_comb begin
      w_state_nx          = r_state;
      w_fetch_pc_nx       = r_fetch_pc;
      w_inflight_pc_nx    = r_inflight_pc;
      w_inflight_valid_nx = r_inflight_valid;
      w_instr_nx          = r_instr;
      w_pc_nx             = r_pc;
      w_valid_nx          = r_valid;
      case (r_state)
         ST_BOOT: begin
            w_inflight_pc_nx    = RESET_PC;
            w_inflight_valid_nx = 1'b1;
            w_fetch_pc_nx       = RESET_PC + 16'd1;
            w_state_nx          = ST_RUN;
         end
         ST_RUN, ST_HALT: begin
            if (w_redirect) begin
               w_inflight_pc_nx    = branch_target;
               w_inflight_valid_nx = 1'b1;
               w_fetch_pc_nx       = branch_target + 16'd1;
               w_valid_nx          = 1'b0;
               w_state_nx          = ST_RUN;
            end else if ((r_state == ST_RUN) && !stall) begin
               if (w_zero_word) begin
                  w_valid_nx = 1'b0;
                  w_state_nx = ST_HALT;
               end else begin
                  w_instr_nx       = imem_instruction;
                  w_pc_nx          = r_inflight_pc;
                  w_valid_nx       = r_inflight_valid;
                  w_inflight_pc_nx = r_fetch_pc;
                  w_fetch_pc_nx    = r_fetch_pc + 16'd1;
               end
            end
         end
         default: begin
            w_state_nx = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state          <= ST_BOOT;
         r_fetch_pc       <= RESET_PC;
         r_inflight_pc    <= RESET_PC;
         r_inflight_valid <= 1'b0;
         r_instr          <= 16'h0000;
         r_pc             <= 16'h0000;
         r_valid          <= 1'b0;
      end else begin
         r_state          <= w_state_nx;
         r_fetch_pc       <= w_fetch_pc_nx;
         r_inflight_pc    <= w_inflight_pc_nx;
         r_inflight_valid <= w_inflight_valid_nx;
         r_instr          <= w_instr_nx;
         r_pc             <= w_pc_nx;
         r_valid          <= w_valid_nx;
      end
   end

   assign instr_out   = r_instr;
   assign pc_out      = r_pc;
   assign instr_valid = r_valid;
   assign halted      = (r_state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// Testbench for fetch_unit: synchronous-read memory, directed scenarios with
// literal expectations, then randomized traffic against a fetch-stream model.
module tb_fetch_unit;

   localparam logic [15:0] RESET_PC = 16'h0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic [15:0] imem_instruction;
   logic [15:0] imem_address;
   logic [15:0] instr_out;
   logic [15:0] pc_out;
   logic        instr_valid;
   logic        halted;

   logic [15:0] mem [0:65535];

   int checks = 0;
   int errors = 0;

   fetch_unit #(.RESET_PC(RESET_PC), .HALT_ON_ZERO(1'b1)) dut (
      .clk              (clk),
      .reset            (reset),
      .stall            (stall),
      .branch_taken     (branch_taken),
      .branch_target    (branch_target),
      .imem_instruction (imem_instruction),
      .imem_address     (imem_address),
      .instr_out        (instr_out),
      .pc_out           (pc_out),
      .instr_valid      (instr_valid),
      .halted           (halted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) imem_instruction <= mem[imem_address];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: the fetch stream is "word at m_req arrives next, then m_nxt";
   // a redirect restarts the stream, a zero word stops it.
   logic        m_boot  = 1'b1;
   logic        m_halt  = 1'b0;
   logic [15:0] m_req   = RESET_PC;
   logic [15:0] m_nxt   = RESET_PC;
   logic        e_valid = 1'b0;
   logic [15:0] e_instr = 16'h0000;
   logic [15:0] e_pc    = 16'h0000;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_boot = 1'b1; m_halt = 1'b0; m_req = RESET_PC; m_nxt = RESET_PC;
         e_valid = 1'b0; e_instr = 16'h0000; e_pc = 16'h0000;
      end else if (m_boot) begin
         m_boot = 1'b0; m_req = RESET_PC; m_nxt = RESET_PC + 16'd1;
      end else if (branch_taken) begin
         m_req = branch_target; m_nxt = branch_target + 16'd1;
         e_valid = 1'b0; m_halt = 1'b0;
      end else if (!m_halt && !stall) begin
         if (mem[m_req] == 16'h0000) begin
            e_valid = 1'b0; m_halt = 1'b1;
         end else begin
            e_instr = mem[m_req]; e_pc = m_req; e_valid = 1'b1;
            m_req = m_nxt; m_nxt = m_nxt + 16'd1;
         end
      end
   end

   function automatic logic [15:0] exp_addr();
      if (branch_taken && !m_boot) return branch_target;
      if (stall && !m_boot && !m_halt) return m_req;
      return m_nxt;
   endfunction

   always @(negedge clk) begin
      chk("valid", {15'd0, instr_valid}, {15'd0, e_valid});
      chk("halted", {15'd0, halted}, {15'd0, m_halt});
      if (e_valid || m_halt || m_boot) begin
         chk("pc_out", pc_out, e_pc);
         chk("instr_out", instr_out, e_instr);
      end
      if (!m_halt || (branch_taken && !m_boot))
         chk("imem_address", imem_address, exp_addr());
   end

   task automatic drive(input logic s, input logic b, input logic [15:0] t);
      stall = s; branch_taken = b; branch_target = t;
      @(posedge clk); #2;
   endtask

   task automatic hold_reset();
      reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
      repeat (2) @(posedge clk);
      #2;
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom_range(1, 65535));
      mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;

      // Sequential fetch, then a 3-cycle stall
      hold_reset();
      chk("reset_instr", instr_out, 16'h0000);
      chk("reset_pc", pc_out, 16'h0000);
      reset = 1'b1;
      drive(0, 0, 0);
      chk("boot_valid", {15'd0, instr_valid}, 16'h0000);
      drive(0, 0, 0);
      chk("seq_instr0", instr_out, 16'h1111); chk("seq_pc0", pc_out, 16'h0000);
      chk("seq_valid0", {15'd0, instr_valid}, 16'h0001);
      drive(0, 0, 0);
      chk("seq_instr1", instr_out, 16'h2222); chk("seq_pc1", pc_out, 16'h0001);
      for (int k = 0; k < 3; k++) begin
         drive(1, 0, 0);
         chk("stall_instr", instr_out, 16'h2222); chk("stall_pc", pc_out, 16'h0001);
      end
      drive(0, 0, 0);
      chk("unstall_instr", instr_out, 16'h3333); chk("unstall_pc", pc_out, 16'h0002);
      drive(0, 0, 0);
      chk("seq_instr3", instr_out, 16'h4444); chk("seq_pc3", pc_out, 16'h0003);

      // Branch, without and with a simultaneous stall; then wrap-around
      for (int k = 0; k < 2; k++) begin
         hold_reset();
         reset = 1'b1;
         repeat (3) drive(0, 0, 0);
         drive(k[0], 1, 16'h0014);
         chk("br_bubble", {15'd0, instr_valid}, 16'h0000);
         drive(0, 0, 0);
         chk("br_pc14", pc_out, 16'h0014); chk("br_valid", {15'd0, instr_valid}, 16'h0001);
         drive(0, 0, 0);
         chk("br_pc15", pc_out, 16'h0015);
      end
      drive(0, 1, 16'hFFFF);
      drive(0, 0, 0);
      chk("wrap_pcffff", pc_out, 16'hFFFF);
      drive(0, 0, 0);
      chk("wrap_pc0", pc_out, 16'h0000); chk("wrap_instr", instr_out, 16'h1111);

      // Halt on zero word, then restart by branch
      hold_reset();
      mem[3] = 16'h0000;
      reset = 1'b1;
      repeat (4) drive(0, 0, 0);
      chk("pre_halt_pc", pc_out, 16'h0002);
      drive(0, 0, 0);
      chk("halt_flag", {15'd0, halted}, 16'h0001);
      chk("halt_valid", {15'd0, instr_valid}, 16'h0000);
      chk("halt_pc", pc_out, 16'h0002);
      for (int k = 0; k < 3; k++) drive(k[0], 0, 0);
      chk("halt_stays", {15'd0, halted}, 16'h0001);
      drive(0, 1, 16'h0000);
      chk("unhalt_flag", {15'd0, halted}, 16'h0000);
      chk("unhalt_bubble", {15'd0, instr_valid}, 16'h0000);
      drive(0, 0, 0);
      chk("unhalt_pc", pc_out, 16'h0000); chk("unhalt_instr", instr_out, 16'h1111);

      // Asynchronous reset between edges during a stall
      hold_reset();
      mem[3] = 16'h4444;
      reset = 1'b1;
      repeat (3) drive(0, 0, 0);
      drive(1, 0, 0);
      reset = 1'b0;
      #1;
      chk("areset_instr", instr_out, 16'h0000); chk("areset_pc", pc_out, 16'h0000);
      chk("areset_valid", {15'd0, instr_valid}, 16'h0000);
      chk("areset_halted", {15'd0, halted}, 16'h0000);
      chk("areset_addr", imem_address, RESET_PC);
      #1;
      reset = 1'b1; stall = 1'b0;
      drive(1, 1, 16'h0050);
      chk("reboot_valid", {15'd0, instr_valid}, 16'h0000);
      drive(0, 0, 0);
      chk("reboot_instr", instr_out, 16'h1111); chk("reboot_pc", pc_out, 16'h0000);

      // Randomized traffic with sparse zero words in the low region
      hold_reset();
      for (int i = 0; i < 256; i++)
         mem[i] = ($urandom_range(0, 19) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
      reset = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         logic        s;
         logic        b;
         logic [15:0] t;
         s = ($urandom_range(0, 9) < 3);
         b = ($urandom_range(0, 99) < 8);
         t = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                         : 16'($urandom_range(0, 255));
         if ($urandom_range(0, 499) == 0) begin
            reset = 1'b0;
            #1;
            chk("rand_areset_valid", {15'd0, instr_valid}, 16'h0000);
            drive(0, 0, 0);
            reset = 1'b1;
         end else begin
            drive(s, b, t);
         end
      end
      drive(0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
